// File: rtl/stat_bench_pkg.sv
// Shared types and defaults for the Stat_* benchmark test harness blocks.
package stat_bench_pkg;

    localparam int          STAT_WIDTH     = 32;
    localparam int          STAT_CNT_W     = 16;
    localparam logic [31:0] STAT_MISR_POLY = 32'h04C11DB7;
    localparam logic [31:0] STAT_MISR_SEED = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_CHECK,
        ST_DONE
    } state_e;

endpackage

// File: rtl/misr_step.sv
// One MISR update: shift left, fold the polynomial back in on MSB carry-out, xor the new word.
module misr_step
    import stat_bench_pkg::*;
#(
    parameter int               WIDTH = STAT_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(STAT_MISR_POLY)
) (
    input  logic [WIDTH-1:0] sig_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] sig_out
);

    always_comb begin
        sig_out = {sig_in[WIDTH-2:0], 1'b0} ^ (sig_in[WIDTH-1] ? POLY : '0) ^ data_in;
    end

endmodule

// File: rtl/stat_response_misr.sv
// Compacts benchmark response words into a MISR and compares the final signature to a golden value.
module stat_response_misr
    import stat_bench_pkg::*;
#(
    parameter int               WIDTH = STAT_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(STAT_MISR_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(STAT_MISR_SEED),
    parameter int               CNT_W = STAT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic [WIDTH-1:0] golden,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] vec_count
);

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] signature_q, signature_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic [CNT_W-1:0] num_vec_q,   num_vec_d;
    logic [WIDTH-1:0] golden_q,    golden_d;
    logic             done_q,      done_d;
    logic             pass_q,      pass_d;

    logic [WIDTH-1:0] sig_next;
    logic [CNT_W-1:0] vec_count_inc;
    logic             accept;

    misr_step #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr_step (
        .sig_in  (signature_q),
        .data_in (resp_data),
        .sig_out (sig_next)
    );

    assign accept        = resp_valid && (state_q == ST_RUN);
    assign vec_count_inc = vec_count_q + CNT_W'(1);

    // NOTE: every _d gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        signature_d = signature_q;
        vec_count_d = vec_count_q;
        num_vec_d   = num_vec_q;
        golden_d    = golden_q;
        done_d      = done_q;
        pass_d      = pass_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_vec_d   = num_vec;
                    golden_d    = golden;
                    signature_d = SEED;
                    vec_count_d = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    state_d     = (num_vec != '0) ? ST_RUN : ST_CHECK;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    signature_d = sig_next;
                    vec_count_d = vec_count_inc;
                    if (vec_count_inc == num_vec_q) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                pass_d  = (signature_q == golden_q);
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            signature_q <= SEED;
            vec_count_q <= '0;
            num_vec_q   <= '0;
            golden_q    <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            signature_q <= signature_d;
            vec_count_q <= vec_count_d;
            num_vec_q   <= num_vec_d;
            golden_q    <= golden_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    // Handshake and status decode only from registered state, never from resp_valid.
    assign resp_ready = (state_q == ST_RUN);
    assign busy       = (state_q == ST_RUN) || (state_q == ST_CHECK);
    assign done       = done_q;
    assign pass       = pass_q;
    assign signature  = signature_q;
    assign vec_count  = vec_count_q;

endmodule

// File: tb/tb_stat_response_misr.sv
// Directed bench for stat_response_misr: driver queues expected run results, a monitor checks them when done rises.
module tb_stat_response_misr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_vec;
    logic [31:0] golden;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] signature;
    logic [15:0] vec_count;

    typedef struct packed {
        logic [31:0] sig;
        logic        pass;
        logic [15:0] vcnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic done_prev = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    stat_response_misr dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_vec    (num_vec),
        .golden     (golden),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .vec_count  (vec_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: each rising done must match the oldest queued run result.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, expected no completed run");
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_signature", signature, mon_e.sig);
                check("mon_pass", pass, mon_e.pass);
                check("mon_vec_count", vec_count, mon_e.vcnt);
            end
        end
        done_prev = done;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected bench to end");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] nv, input logic [31:0] g);
        start   = 1'b1;
        num_vec = nv;
        golden  = g;
        tick();
        start   = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        bit acc = 1'b0;
        resp_valid = 1'b1;
        resp_data  = d;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = resp_ready;
            tick();
        end
        resp_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got resp_ready=0 for 20 cycles, expected 1");
        end
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check(name, done, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        num_vec    = '0;
        golden     = '0;
        resp_valid = 1'b0;
        resp_data  = '0;
        tick();
        tick();
        @(negedge clk);
        check("rst_signature", signature, 32'hFFFFFFFF);
        check("rst_vec_count", vec_count, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_busy", busy, 0);
        check("rst_resp_ready", resp_ready, 0);
        rst_n = 1'b1;
        tick();

        // Single zero word, with completion latency checked edge by edge.
        exp_q.push_back('{sig: 32'hFB3EE249, pass: 1'b1, vcnt: 16'd1});
        do_start(16'd1, 32'hFB3EE249);
        send(32'h0);
        @(negedge clk);
        check("t1_done_low_in_check", done, 0);
        check("t1_busy_in_check", busy, 1);
        @(negedge clk);
        check("t1_done_high", done, 1);
        tick();

        // Two words, matching golden then a wrong golden.
        exp_q.push_back('{sig: 32'hF2BCD924, pass: 1'b1, vcnt: 16'd2});
        do_start(16'd2, 32'hF2BCD924);
        send(32'h0);
        send(32'h1);
        wait_done("t2_done");
        tick();

        exp_q.push_back('{sig: 32'hF2BCD924, pass: 1'b0, vcnt: 16'd2});
        do_start(16'd2, 32'h0);
        send(32'h0);
        send(32'h1);
        wait_done("t3_done");
        tick();

        // Bubbles between beats leave the run untouched.
        exp_q.push_back('{sig: 32'hF2BCD924, pass: 1'b1, vcnt: 16'd2});
        do_start(16'd2, 32'hF2BCD924);
        send(32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_bubble_ready", resp_ready, 1);
            check("t4_bubble_vec_count", vec_count, 1);
            check("t4_bubble_signature", signature, 32'hFB3EE249);
            tick();
        end
        send(32'h1);
        wait_done("t4_done");
        tick();

        // Empty run goes straight to CHECK.
        exp_q.push_back('{sig: 32'hFFFFFFFF, pass: 1'b1, vcnt: 16'd0});
        do_start(16'd0, 32'hFFFFFFFF);
        @(negedge clk);
        check("t5_done_low", done, 0);
        check("t5_busy", busy, 1);
        check("t5_ready_check", resp_ready, 0);
        @(negedge clk);
        check("t5_done_high", done, 1);
        check("t5_ready_done", resp_ready, 0);
        tick();

        // Start while busy is ignored; original num_vec and golden stay in force.
        exp_q.push_back('{sig: 32'hF2BCD924, pass: 1'b1, vcnt: 16'd2});
        do_start(16'd2, 32'hF2BCD924);
        send(32'h0);
        do_start(16'd5, 32'h0);
        @(negedge clk);
        check("t6_busy_after_ignored_start", busy, 1);
        check("t6_vec_count_kept", vec_count, 1);
        tick();
        send(32'h1);
        wait_done("t6_done");
        tick();

        // Restart from DONE: done drops and the signature reseeds on the start edge.
        exp_q.push_back('{sig: 32'h1E475000, pass: 1'b1, vcnt: 16'd3});
        do_start(16'd3, 32'h1E475000);
        @(negedge clk);
        check("t7_done_dropped", done, 0);
        check("t7_signature_seed", signature, 32'hFFFFFFFF);
        check("t7_vec_count_zero", vec_count, 0);
        tick();
        send(32'h0);
        send(32'h1);
        send(32'hFFFFFFFF);
        wait_done("t7_done");
        tick();

        // Reset mid-run discards the partial signature; held words are not consumed.
        do_start(16'd10, 32'h0);
        for (int i = 0; i < 5; i++) send(32'h100 + 32'(i));
        @(negedge clk);
        check("t8_vec_count_mid", vec_count, 5);
        tick();
        resp_valid = 1'b1;
        resp_data  = 32'h55;
        rst_n      = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("t8_rst_signature", signature, 32'hFFFFFFFF);
        check("t8_rst_vec_count", vec_count, 0);
        check("t8_rst_done", done, 0);
        check("t8_rst_ready", resp_ready, 0);
        check("t8_rst_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("t8_post_rst_vec_count", vec_count, 0);
            check("t8_post_rst_signature", signature, 32'hFFFFFFFF);
        end
        resp_valid = 1'b0;
        tick();
        tick();
        tick();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
